// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO: the controller state encoding and
// the occupancy-counter width helper.
package fifo_pkg;

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      IDLE     = 3'd1,
      WRITE    = 3'd2,
      WR_ERROR = 3'd3,
      READ     = 3'd4,
      RD_ERROR = 3'd5,
      WR_RD    = 3'd6
   } fifo_state_e;

   // One extra bit over the pointer width so that DEPTH itself is representable.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read, no reset.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read-before-write on a shared address: a full FIFO doing read+write
   // returns the oldest entry, not the one being written.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: control FSM recording the last action, pointers,
// occupancy count, threshold flags and one-cycle ack/err pulses.
//
// state    | meaning
// ---------+------------------------------------------------
// INIT     | first cycle after reset, requests ignored
// IDLE     | no request on the last edge
// WRITE    | write accepted on the last edge
// WR_ERROR | write rejected (full) on the last edge
// READ     | read accepted on the last edge
// RD_ERROR | read rejected (empty) on the last edge
// WR_RD    | read and write both accepted on the last edge
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AFULL_TH   = DEPTH - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic [$clog2(DEPTH):0]   data_count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     wr_ack,
   output logic                     rd_ack,
   output logic                     wr_err,
   output logic                     rd_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   fifo_state_e   state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rd_rej_q, rd_rej_d;
   logic          dout_vld_q, dout_vld_d;
   logic          do_wr, do_rd;
   logic          is_full, is_empty;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign is_full  = (count_q == DEPTH_C);
   assign is_empty = (count_q == '0);

   always_comb begin
      state_d  = IDLE;
      rd_rej_d = 1'b0;
      if (state_q != INIT) begin
         unique case ({wr_en, rd_en})
            2'b10: state_d = is_full  ? WR_ERROR : WRITE;
            2'b01: state_d = is_empty ? RD_ERROR : READ;
            2'b11: begin
               // Empty: no fall-through, the write lands and the read is refused.
               state_d  = is_empty ? WRITE : WR_RD;
               rd_rej_d = is_empty;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      do_wr      = (state_d == WRITE) || (state_d == WR_RD);
      do_rd      = (state_d == READ)  || (state_d == WR_RD);
      wr_ptr_d   = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (do_wr && !do_rd) count_d = count_q + 1'b1;
      if (do_rd && !do_wr) count_d = count_q - 1'b1;
      dout_vld_d = dout_vld_q || do_rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_rej_q   <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_rej_q   <= rd_rej_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (do_wr),
      .waddr (wr_ptr_q),
      .wdata (din),
      .re    (do_rd),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // The RAM output register has no reset; mask it until the first accepted read.
   assign dout         = dout_vld_q ? ram_rdata : '0;
   assign data_count   = count_q;
   assign full         = is_full;
   assign empty        = is_empty;
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign wr_ack       = (state_q == WRITE) || (state_q == WR_RD);
   assign rd_ack       = (state_q == READ)  || (state_q == WR_RD);
   assign wr_err       = (state_q == WR_ERROR);
   assign rd_err       = (state_q == RD_ERROR) || rd_rej_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync (DEPTH=8, DATA_WIDTH=8).
module tb_fifo_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en;
   logic [7:0] din;
   logic [7:0] dout;
   logic [3:0] data_count;
   logic       full, empty, almost_full, almost_empty;
   logic       wr_ack, rd_ack, wr_err, rd_err;

   int total = 0;
   int bad   = 0;

   fifo_sync #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .data_count   (data_count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .wr_ack       (wr_ack),
      .rd_ack       (rd_ack),
      .wr_err       (wr_err),
      .rd_err       (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request, clock it, and land 1 time unit after the edge.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   // ack/err pulse vector as {wr_ack, rd_ack, wr_err, rd_err}
   function automatic logic [3:0] pulses();
      return {wr_ack, rd_ack, wr_err, rd_err};
   endfunction

   function automatic logic [3:0] flags();
      return {full, almost_full, empty, almost_empty};
   endfunction

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
      #12;
      chk("reset_count", 32'(data_count), 0);
      chk("reset_flags", 32'(flags()), 32'b0011);
      chk("reset_pulses", 32'(pulses()), 0);
      chk("reset_dout", 32'(dout), 0);

      @(posedge clk); #1;
      rst = 1'b0;
      // INIT edge: request ignored
      step(1'b1, 1'b1, 8'hEE);
      chk("init_pulses", 32'(pulses()), 0);
      chk("init_count", 32'(data_count), 0);

      step(1'b0, 1'b1, 8'h00);
      chk("empty_rd_pulses", 32'(pulses()), 32'b0001);
      chk("empty_rd_dout", 32'(dout), 0);
      chk("empty_rd_count", 32'(data_count), 0);
      step(1'b0, 1'b0, 8'h00);
      chk("idle_pulses", 32'(pulses()), 0);

      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 8'(i));
         chk("fill_pulses", 32'(pulses()), 32'b1000);
         chk("fill_count", 32'(data_count), 32'(i));
         chk("fill_flags", 32'(flags()),
             32'({i == 8, i >= 6, 1'b0, i <= 2}));
      end

      step(1'b1, 1'b0, 8'h99);
      chk("overflow_pulses", 32'(pulses()), 32'b0010);
      chk("overflow_count", 32'(data_count), 8);
      step(1'b0, 1'b0, 8'h00);
      chk("overflow_clear", 32'(pulses()), 0);

      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         chk("drain_pulses", 32'(pulses()), 32'b0100);
         chk("drain_dout", 32'(dout), 32'(i));
         chk("drain_count", 32'(data_count), 32'(8 - i));
      end
      chk("drain_empty", 32'(flags()), 32'b0011);

      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
      chk("refill_count", 32'(data_count), 8);
      step(1'b1, 1'b1, 8'h19);
      chk("wrrd_full_pulses", 32'(pulses()), 32'b1100);
      chk("wrrd_full_dout", 32'(dout), 32'h11);
      chk("wrrd_full_count", 32'(data_count), 8);

      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'h00);
         chk("part_drain_dout", 32'(dout), 32'(8'h12 + i));
      end
      chk("part_drain_count", 32'(data_count), 4);
      step(1'b1, 1'b1, 8'h1A);
      chk("wrrd_mid_pulses", 32'(pulses()), 32'b1100);
      chk("wrrd_mid_dout", 32'(dout), 32'h16);
      chk("wrrd_mid_count", 32'(data_count), 4);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'h00);
         chk("tail_dout", 32'(dout), 32'(8'h17 + i));
      end
      chk("tail_count", 32'(data_count), 0);

      step(1'b1, 1'b1, 8'h2B);
      chk("wrrd_empty_pulses", 32'(pulses()), 32'b1001);
      chk("wrrd_empty_count", 32'(data_count), 1);
      chk("wrrd_empty_dout", 32'(dout), 32'h1A);
      step(1'b0, 1'b1, 8'h00);
      chk("wrrd_empty_read", 32'(dout), 32'h2B);
      chk("wrrd_empty_read_count", 32'(data_count), 0);

      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b0, 8'(8'h40 + i));
         chk("ilv_wr_count", 32'(data_count), 1);
         step(1'b0, 1'b1, 8'h00);
         chk("ilv_rd_dout", 32'(dout), 32'(8'h40 + i));
      end
      chk("ilv_flags", 32'(flags()), 32'b0011);

      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
      chk("burst_count", 32'(data_count), 5);
      #2 rst = 1'b1;
      #1;
      chk("midrst_count", 32'(data_count), 0);
      chk("midrst_flags", 32'(flags()), 32'b0011);
      chk("midrst_pulses", 32'(pulses()), 0);
      chk("midrst_dout", 32'(dout), 0);
      wr_en = 1'b0; rd_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      chk("postrst_rd_err", 32'(pulses()), 32'b0001);
      chk("postrst_count", 32'(data_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
